// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : md_ctrl
// Description : Multi-cycle multiply/divide sequencer for the E stage. Owns
//               HI/LO, models fixed execution latency, raises D-stage stall.
// Revision    : 1.0 - initial release
// ============================================================================
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdop,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_D,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall
);

    localparam logic [2:0] C_OP_MULT  = 3'd1;
    localparam logic [2:0] C_OP_MULTU = 3'd2;
    localparam logic [2:0] C_OP_DIV   = 3'd3;
    localparam logic [2:0] C_OP_DIVU  = 3'd4;
    localparam logic [2:0] C_OP_MTHI  = 3'd5;
    localparam logic [2:0] C_OP_MTLO  = 3'd6;
    localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] hi_q, lo_q, hi_n_q, lo_n_q;
    logic [31:0] hi_n_d, lo_n_d;

    logic        w_is_md;
    logic        w_sdiv;
    logic [63:0] w_prod_s, w_prod_u;
    logic [31:0] w_dvd, w_dvs, w_quo_mag, w_rem_mag, w_quo, w_rem;

    assign w_is_md = (mdop >= C_OP_MULT) && (mdop <= C_OP_DIVU);
    assign w_sdiv  = (mdop == C_OP_DIV);

    assign w_prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign w_prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide works on magnitudes; 0x80000000 stays 2^31 as unsigned.
    assign w_dvd     = (w_sdiv && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
    assign w_dvs     = (w_sdiv && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
    assign w_quo_mag = (w_dvs == 32'd0) ? 32'd0 : (w_dvd / w_dvs);
    assign w_rem_mag = (w_dvs == 32'd0) ? 32'd0 : (w_dvd % w_dvs);
    assign w_quo     = (w_sdiv && (rs_val[31] ^ rt_val[31])) ? (32'd0 - w_quo_mag) : w_quo_mag;
    assign w_rem     = (w_sdiv && rs_val[31]) ? (32'd0 - w_rem_mag) : w_rem_mag;

    // Divide by zero shadows the current HI/LO so the commit is a no-op.
    always_comb begin
        hi_n_d = hi_q;
        lo_n_d = lo_q;
        case (mdop)
            C_OP_MULT:  {hi_n_d, lo_n_d} = w_prod_s;
            C_OP_MULTU: {hi_n_d, lo_n_d} = w_prod_u;
            C_OP_DIV, C_OP_DIVU: begin
                if (rt_val != 32'd0) begin
                    hi_n_d = w_rem;
                    lo_n_d = w_quo;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_n_q  <= 32'd0;
            lo_n_q  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (w_is_md) begin
                            hi_n_q  <= hi_n_d;
                            lo_n_q  <= lo_n_d;
                            cnt_q   <= (mdop >= C_OP_DIV) ? C_DIV_CNT : C_MULT_CNT;
                            state_q <= RUN;
                        end else if (mdop == C_OP_MTHI) begin
                            hi_q <= rs_val;
                        end else if (mdop == C_OP_MTLO) begin
                            lo_q <= rs_val;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        hi_q    <= hi_n_q;
                        lo_q    <= lo_n_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = (state_q == RUN);
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = md_use_D & (busy | (start & w_is_md));

endmodule
`default_nettype wire

// File: doc/md_ctrl.md
# md_ctrl

Multi-cycle multiply/divide sequencer for the E stage of the pipelined MIPS CPU. It latches operands when the E-stage controller issues a mult/div-class operation and models fixed-latency execution with a busy counter. It owns the HI/LO registers and raises the stall request that freezes D when a HI/LO-dependent instruction would collide with an operation in flight.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (1..15).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (1..15).
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `start` input, 1 bit: an md operation is in E this cycle.
- `mdop` input, 3 bits: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- `rs_val` input, 32 bits: forwarded rs operand in E (dividend / multiplicand / mthi-mtlo source).
- `rt_val` input, 32 bits: forwarded rt operand in E (divisor / multiplier).
- `md_use_D` input, 1 bit: the instruction in D is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- `busy` output, 1 bit: an operation is in flight.
- `hi` output, 32 bits: architectural HI.
- `lo` output, 32 bits: architectural LO.
- `stall` output, 1 bit: stall request to the hazard unit (combinational).

## Operation
- States: IDLE (`busy`=0) and RUN (`busy`=1, 4-bit down-counter `cnt`).
- IDLE, `start`=1, `mdop` 1..4: latch the full result into shadow registers `hi_n`/`lo_n`. Load `cnt` with MULT_CYCLES or DIV_CYCLES and enter RUN.
- IDLE, `start`=1, `mdop` 5/6: write `rs_val` to `hi`/`lo` at that edge. Stay in IDLE, with no busy cycle.
- IDLE, `start`=1, `mdop` 0 or 7: no effect.
- RUN: decrement `cnt` each edge. On the edge where `cnt`==1, copy `hi_n`/`lo_n` into `hi`/`lo`, clear `busy` and return to IDLE.
- `start` during RUN is ignored: no state, operand or HI/LO change. The hazard unit must prevent this through `stall`; the bench checks that the unit ignores it.
- Arithmetic:
  - mult: signed 32x32 to 64; `hi`=[63:32], `lo`=[31:0].
  - multu: same, unsigned.
  - div: `lo` = signed quotient truncated toward zero; `hi` = remainder with the sign of the dividend.
  - divu: the same, unsigned.
- Divide by zero (`rt_val`=0, div/divu): runs the full DIV_CYCLES busy period, and `hi`/`lo` are left unchanged at completion.
- Signed div of 0x80000000 by 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
- `stall` = `md_use_D` & (`busy` | (`start` & `mdop` in 1..4)).

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, `cnt`=0, shadows 0, state IDLE. `stall` is 0 whenever `md_use_D`=0.
- Issue at edge E0 (`start` sampled):
  - `busy` is high for exactly N cycles after E0 (N = MULT_CYCLES or DIV_CYCLES).
  - `hi`/`lo` show the new values starting at the first cycle with `busy`=0.
- mthi/mtlo: the new value is visible the cycle after the issuing edge.
- Back-to-back issue: a new `start` in the first cycle with `busy`=0 is accepted. Zero idle gap is required.
- Reset asserted mid-RUN: at that edge the operation is abandoned and all state returns to reset values. No partial HI/LO commit.
- Reset and `start` in the same cycle: reset wins.

## Test plan
- mult: `rs_val`=0xFFFFFFFD (-3), `rt_val`=5 -> `busy` high 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. `hi`/`lo` stay unchanged while busy.
- multu: 0xFFFFFFFF * 2 -> `hi`=0x00000001, `lo`=0xFFFFFFFE after 5 cycles. Back-to-back divu 7/2 issued the next cycle -> `busy` high 10 more cycles, then `hi`=1, `lo`=3.
- div:
  - -7/2 (0xFFFFFFF9, 2) -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
  - 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
  - div by zero with prior `hi`=0x1234, `lo`=0x5678 -> busy 10 cycles, values unchanged.
- mthi `rs_val`=0xDEADBEEF in IDLE -> `hi`=0xDEADBEEF next cycle and `busy` stays 0. mtlo issued during RUN -> ignored, `lo` keeps the pending op result.
- Stall: `md_use_D`=1 in the issue cycle and throughout busy -> `stall`=1 for 1+N cycles and 0 in the first idle cycle. `md_use_D`=0 during busy -> `stall`=0.
- Reset asserted in the 3rd busy cycle of a mult -> next cycle `busy`=0, `hi`=`lo`=0. Continue 10 cycles with no commit.
